serial_rx_control: RTL and testbench
====================================

Name: serial_rx_control

Overview:
- Receive sequencer for the serial port's asynchronous modes 1, 2 and 3.
- Detects the start bit on RXD, oversamples each bit with a 3-sample majority vote, and drives the start, shift and load strobes of the RX input shift register.
- Decides from the SCON flags whether the received frame is loaded into SBUF and whether RI is set.
- Sits between the baud-rate generator, the SCON register and serial_rx_input_shifter_reg.

Parameters:
OVERSAMPLE, 16, rx ticks per bit time; counter width is clog2(OVERSAMPLE).
VOTE_MID, 8, centre sample index; votes use indices VOTE_MID-1, VOTE_MID and VOTE_MID+1.
N_SHIFT, 9, bits shifted per frame: 8 data bits plus the 9th bit (the stop bit in mode 1, TB8/RB8 in modes 2 and 3).

Ports:
serial_clock_i  in  1  system clock; all logic is on the rising edge.
serial_reset_i  in  1  synchronous reset, active-high.
serial_rx_tick_i  in  1  one-clock pulse at OVERSAMPLE x baud rate.
serial_rxd_i  in  1  asynchronous RXD pin.
serial_scon4_ren_i  in  1  receive enable.
serial_scon7_sm0_i  in  1  mode bit SM0.
serial_scon6_sm1_i  in  1  mode bit SM1.
serial_scon5_sm2_i  in  1  multiprocessor enable.
serial_scon0_ri_i  in  1  current RI flag.
serial_start_input_shift_reg_o  out  1  one-cycle pulse that clears the shifter at frame start.
serial_shift_input_shift_reg_o  out  1  one-cycle pulse per voted bit.
serial_data_o  out  1  voted bit value; stable whenever the shift pulse is high.
serial_receive_o  out  1  high while a frame is in progress.
serial_load_sbuf_o  out  1  one-cycle pulse that copies the shifter into SBUF and RB8.
serial_set_ri_o  out  1  one-cycle pulse that sets RI; coincides with the load pulse.
serial_rx_busy_o  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: all strobes = 0, serial_receive_o = 0, serial_rx_busy_o = 0, serial_data_o = 1.
- Internal state after reset: FSM = IDLE, counters = 0, RXD synchroniser = 1.
- RXD passes through a 2-flop synchroniser. All sampling and edge detection use the synchronised value, evaluated only on cycles where serial_rx_tick_i = 1.
- Mode 0 (SM0 = 0, SM1 = 0): the FSM stays in IDLE. Mode 0 reception is handled elsewhere.
- The mode is latched at frame start. Mode changes during a frame are ignored.
- IDLE:
  - Exit condition: REN = 1, mode != 0, and on a tick the synchronised RXD is 0 while it was 1 on the previous tick.
  - Action: tick_cnt <= 0, go to START, pulse start_input_shift_reg_o next cycle, assert receive_o.
- START:
  - tick_cnt increments on each tick.
  - At tick VOTE_MID+1, evaluate the majority of the 3 samples. Vote = 1 means a false start: return to IDLE with receive_o = 0 and no further strobes.
  - At tick OVERSAMPLE-1, go to DATA with bit_cnt <= 0 and tick_cnt <= 0.
- DATA:
  - At tick VOTE_MID+1: serial_data_o <= vote and shift_input_shift_reg_o <= 1 (registered together; the pulse lasts one cycle). bit_cnt then increments.
  - If bit_cnt reaches N_SHIFT at this point, go to LOAD. No stop-bit wait follows in any mode.
  - Otherwise, at tick OVERSAMPLE-1, tick_cnt <= 0 and remain in DATA.
- LOAD (exactly one cycle):
  - Condition: RI = 0 and (SM2 = 0 or last voted bit = 1).
  - If the condition holds, pulse load_sbuf_o and set_ri_o in the same cycle. Otherwise there is no pulse and the frame is discarded.
  - Next state is IDLE; receive_o falls with the transition to IDLE.
- REN = 0 in any non-IDLE state aborts to IDLE on the next clock with no shift, load or RI pulse.
- A falling edge on RXD during a frame is ignored. A new frame requires re-entering IDLE and a fresh 1-to-0 transition.
- Reset mid-frame returns to IDLE immediately with all outputs at their reset values.
- At most one strobe per cycle, except load and set_ri, which always coincide.
- A tick that arrives in the same cycle as a state transition is consumed by the new state.

Test Plan:
- Mode 1, REN = 1, RI = 0, SM2 = 0: send 0xA5 LSB-first plus stop bit 1 at 16 ticks/bit -> 1 start pulse; 9 shift pulses with data_o = 1,0,1,0,0,1,0,1,1; one load/set_ri pulse 1 cycle after the 9th shift; receive_o then 0.
- False start: RXD low for 4 ticks, then high -> 1 start pulse, 0 shift pulses, receive_o back to 0 after tick 9; a following valid frame 0x3C is received correctly.
- Mode 2, SM2 = 1: send 0x55 with 9th bit 0 -> 9 shifts and no load pulse; resend with 9th bit 1 -> load and set_ri pulse.
- Mode 3, RI = 1: valid frame 0xFF with 9th bit 1 -> 9 shifts and no load/set_ri.
- Glitch rejection: data bit 2 samples at indices 7/8/9 = 1/0/1 -> data_o = 1 on the 3rd shift.
- Abort: REN dropped after the 4th shift -> no further shift pulses, no load, busy = 0 next cycle. Repeat the mid-frame abort with reset = 1 -> all outputs at reset values, data_o = 1.

Source files
------------

// File: rtl/serial_rx_control_if.sv
`default_nettype none
// ============================================================================
// serial_rx_control_if : RXD/tick/SCON inputs and shifter/SBUF strobes of the RX sequencer
// Revision: 1.0
// ============================================================================
interface serial_rx_control_if;
  logic serial_rx_tick_i;
  logic serial_rxd_i;
  logic serial_scon4_ren_i;
  logic serial_scon7_sm0_i;
  logic serial_scon6_sm1_i;
  logic serial_scon5_sm2_i;
  logic serial_scon0_ri_i;
  logic serial_start_input_shift_reg_o;
  logic serial_shift_input_shift_reg_o;
  logic serial_data_o;
  logic serial_receive_o;
  logic serial_load_sbuf_o;
  logic serial_set_ri_o;
  logic serial_rx_busy_o;

  // master: the surrounding serial port (baud generator, SCON, pin)
  modport master (
    output serial_rx_tick_i, serial_rxd_i, serial_scon4_ren_i, serial_scon7_sm0_i,
           serial_scon6_sm1_i, serial_scon5_sm2_i, serial_scon0_ri_i,
    input  serial_start_input_shift_reg_o, serial_shift_input_shift_reg_o, serial_data_o,
           serial_receive_o, serial_load_sbuf_o, serial_set_ri_o, serial_rx_busy_o
  );

  modport slave (
    input  serial_rx_tick_i, serial_rxd_i, serial_scon4_ren_i, serial_scon7_sm0_i,
           serial_scon6_sm1_i, serial_scon5_sm2_i, serial_scon0_ri_i,
    output serial_start_input_shift_reg_o, serial_shift_input_shift_reg_o, serial_data_o,
           serial_receive_o, serial_load_sbuf_o, serial_set_ri_o, serial_rx_busy_o
  );
endinterface
`default_nettype wire

// File: rtl/serial_rx_control.sv
`default_nettype none
// ============================================================================
// serial_rx_control : async-mode (1/2/3) receive sequencer with 3-sample majority vote
// Revision: 1.0
// ============================================================================
module serial_rx_control #(
  parameter int OVERSAMPLE = 16,
  parameter int VOTE_MID   = 8,
  parameter int N_SHIFT    = 9
) (
  input  logic               serial_clock_i,
  input  logic               serial_reset_i,
  serial_rx_control_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(N_SHIFT + 1);
  localparam logic [CW-1:0] VOTE_LO   = CW'(VOTE_MID - 1);
  localparam logic [CW-1:0] VOTE_C    = CW'(VOTE_MID);
  localparam logic [CW-1:0] VOTE_HI   = CW'(VOTE_MID + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N_SHIFT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, LOAD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [1:0]    samp, samp_n;
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          data, data_n;
  logic          start_p, start_n;
  logic          shift_p, shift_n;
  logic          load_p, load_n;

  logic tick, ren, mode_on, vote;
  assign tick    = bus.serial_rx_tick_i;
  assign ren     = bus.serial_scon4_ren_i;
  assign mode_on = bus.serial_scon7_sm0_i | bus.serial_scon6_sm1_i;
  // Third vote sample is the live synchronised value on the VOTE_MID+1 tick
  assign vote    = (samp[0] & samp[1]) | (samp[0] & rxd_sync) | (samp[1] & rxd_sync);

  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samp     <= '0;
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      data     <= 1'b1;
      start_p  <= 1'b0;
      shift_p  <= 1'b0;
      load_p   <= 1'b0;
    end else begin
      rxd_meta <= bus.serial_rxd_i;
      rxd_sync <= rxd_meta;
      if (tick) rxd_prev <= rxd_sync;
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      samp     <= samp_n;
      data     <= data_n;
      start_p  <= start_n;
      shift_p  <= shift_n;
      load_p   <= load_n;
    end
  end

  // Mode is only consulted in IDLE, so a mid-frame mode change has no effect
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    samp_n  = samp;
    data_n  = data;
    start_n = 1'b0;
    shift_n = 1'b0;
    load_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && ren && mode_on && !rxd_sync && rxd_prev) begin
          state_n = START;
          tick_n  = '0;
          start_n = 1'b1;
        end
      end
      START, DATA: begin
        if (!ren) begin
          state_n = IDLE;
        end else if (tick) begin
          tick_n = tick_cnt + 1'b1;
          if (tick_cnt == VOTE_LO) samp_n[0] = rxd_sync;
          if (tick_cnt == VOTE_C)  samp_n[1] = rxd_sync;
          if (state == START) begin
            if (tick_cnt == VOTE_HI && vote) begin
              state_n = IDLE;
            end else if (tick_cnt == TICK_LAST) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end
          end else if (tick_cnt == VOTE_HI) begin
            data_n  = vote;
            shift_n = 1'b1;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_n = LOAD;
          end else if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
          end
        end
      end
      LOAD: begin
        // data holds the last voted bit (the 9th bit) here
        state_n = IDLE;
        load_n  = ren && !bus.serial_scon0_ri_i && (!bus.serial_scon5_sm2_i || data);
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.serial_start_input_shift_reg_o = start_p;
  assign bus.serial_shift_input_shift_reg_o = shift_p;
  assign bus.serial_data_o                  = data;
  assign bus.serial_receive_o               = (state != IDLE);
  assign bus.serial_rx_busy_o               = (state != IDLE);
  assign bus.serial_load_sbuf_o             = load_p;
  assign bus.serial_set_ri_o                = load_p;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_control.sv
`default_nettype none
// ============================================================================
// tb_serial_rx_control : randomized + directed bench with a tick-level reference model
// Revision: 1.0
// ============================================================================
module tb_serial_rx_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_rx_control_if bus();

  serial_rx_control dut (
    .serial_clock_i (clk),
    .serial_reset_i (rst),
    .bus            (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: counts strobes and flags protocol violations on every clock
  int cyc = 0, last_shift_cyc = -10;
  int n_start = 0, n_shift = 0, n_load = 0, n_ri = 0, n_bad = 0;
  bit shift_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.serial_start_input_shift_reg_o) n_start++;
      if (bus.serial_shift_input_shift_reg_o) begin
        shift_q.push_back(bus.serial_data_o);
        n_shift++;
        last_shift_cyc = cyc;
        if (!bus.serial_receive_o) n_bad++;
      end
      if (bus.serial_load_sbuf_o) begin
        n_load++;
        if (cyc != last_shift_cyc + 1 || bus.serial_receive_o) n_bad++;
      end
      if (bus.serial_set_ri_o) n_ri++;
      if (bus.serial_set_ri_o != bus.serial_load_sbuf_o) n_bad++;
      if (int'(bus.serial_start_input_shift_reg_o) + int'(bus.serial_shift_input_shift_reg_o)
          + int'(bus.serial_load_sbuf_o) > 1) n_bad++;
      if (bus.serial_rx_busy_o != bus.serial_receive_o) n_bad++;
    end
  end

  // Stimulus: one synchronised RXD value per rx tick
  bit stim[$];

  task automatic slot(input bit v);
    bus.serial_rxd_i     = v;
    bus.serial_rx_tick_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.serial_rx_tick_i = 1'b1;
    @(negedge clk);
    bus.serial_rx_tick_i = 1'b0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'b1);
  endtask

  // Appends start bit, 8 data bits LSB first and the 9th bit; returns start-bit index
  function automatic int add_frame(input logic [7:0] d, input bit b9);
    int e;
    logic [8:0] w;
    e = stim.size();
    w = {b9, d};
    for (int i = 0; i < 16; i++) stim.push_back(1'b0);
    for (int j = 0; j < 9; j++)
      for (int i = 0; i < 16; i++) stim.push_back(w[j]);
    return e;
  endfunction

  // Reference model: falling edge at tick k opens a frame; start vote on
  // ticks k+8..k+10, data bit j voted on ticks k+24+16j .. k+26+16j.
  int exp_start, exp_shift, exp_load;
  logic [63:0] exp_bits;

  function automatic bit at(input int i);
    return (i < stim.size()) ? stim[i] : 1'b1;
  endfunction

  function automatic bit maj(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  task automatic run_model(input bit mode_on, input bit ri, input bit sm2);
    int k, b;
    bit prev, v;
    exp_start = 0; exp_shift = 0; exp_load = 0; exp_bits = '0;
    prev = 1'b1;
    k = 0;
    while (k < stim.size()) begin
      if (mode_on && prev && !stim[k]) begin
        exp_start++;
        if (maj(at(k+8), at(k+9), at(k+10))) begin
          prev = at(k+10);
          k = k + 11;
        end else begin
          v = 1'b1;
          b = 0;
          for (int j = 0; j < 9; j++) begin
            b = k + 17 + 16*j;
            v = maj(at(b+7), at(b+8), at(b+9));
            if (exp_shift < 64) exp_bits[exp_shift] = v;
            exp_shift++;
          end
          if (!ri && (!sm2 || v)) exp_load++;
          prev = at(b+9);
          k = b + 10;
        end
      end else begin
        prev = stim[k];
        k++;
      end
    end
  endtask

  task automatic run_stream(input string tag, input bit s0, input bit s1, input bit sm2, input bit ri);
    int bs, bl, br, bb, bq;
    logic [63:0] gv;
    bus.serial_scon7_sm0_i = s0;
    bus.serial_scon6_sm1_i = s1;
    bus.serial_scon5_sm2_i = sm2;
    bus.serial_scon0_ri_i  = ri;
    bus.serial_scon4_ren_i = 1'b1;
    run_model(s0 | s1, ri, sm2);
    bs = n_start; bl = n_load; br = n_ri; bb = n_bad; bq = shift_q.size();
    foreach (stim[i]) slot(stim[i]);
    repeat (6) @(negedge clk);
    #1;
    gv = '0;
    for (int i = 0; i < shift_q.size() - bq && i < 64; i++) gv[i] = shift_q[bq+i];
    check_value({tag, "/starts"}, 64'(n_start - bs), 64'(exp_start));
    check_value({tag, "/shifts"}, 64'(shift_q.size() - bq), 64'(exp_shift));
    check_value({tag, "/bits"},   gv, exp_bits);
    check_value({tag, "/loads"},  64'(n_load - bl), 64'(exp_load));
    check_value({tag, "/set_ri"}, 64'(n_ri - br), 64'(exp_load));
    check_value({tag, "/protocol"}, 64'(n_bad - bb), 64'd0);
    stim.delete();
  endtask

  function automatic logic [6:0] out_vec();
    return {bus.serial_start_input_shift_reg_o, bus.serial_shift_input_shift_reg_o,
            bus.serial_data_o, bus.serial_receive_o, bus.serial_load_sbuf_o,
            bus.serial_set_ri_o, bus.serial_rx_busy_o};
  endfunction

  task automatic run_abort(input bit use_rst);
    int idx, bq, bl;
    bit hit;
    void'(add_frame(8'h00, 1'b0));
    stim.delete();
    add_idle(4);
    void'(add_frame(8'hA5, 1'b1));
    add_idle(20);
    bus.serial_scon7_sm0_i = 1'b0;
    bus.serial_scon6_sm1_i = 1'b1;
    bus.serial_scon5_sm2_i = 1'b0;
    bus.serial_scon0_ri_i  = 1'b0;
    bus.serial_scon4_ren_i = 1'b1;
    bq = shift_q.size(); bl = n_load;
    hit = 1'b0;
    idx = 0;
    while (idx < stim.size() && !hit) begin
      slot(stim[idx]);
      idx++;
      #1;
      if (shift_q.size() - bq == 4) hit = 1'b1;
    end
    check_value(use_rst ? "rst_abort/reach4" : "ren_abort/reach4", 64'(hit), 64'd1);
    if (use_rst) begin
      rst = 1'b1;
      @(negedge clk);
      check_value("rst_abort/outputs", 64'(out_vec()), 64'(7'b0010000));
      rst = 1'b0;
      bus.serial_rxd_i = 1'b1;
      for (int i = 0; i < 30; i++) slot(1'b1);
    end else begin
      bus.serial_scon4_ren_i = 1'b0;
      @(negedge clk);
      check_value("ren_abort/busy", 64'(bus.serial_rx_busy_o), 64'd0);
      check_value("ren_abort/receive", 64'(bus.serial_receive_o), 64'd0);
      while (idx < stim.size()) begin
        slot(stim[idx]);
        idx++;
      end
      bus.serial_scon4_ren_i = 1'b1;
      for (int i = 0; i < 4; i++) slot(1'b1);
    end
    repeat (4) @(negedge clk);
    #1;
    check_value(use_rst ? "rst_abort/shifts" : "ren_abort/shifts", 64'(shift_q.size() - bq), 64'd4);
    check_value(use_rst ? "rst_abort/loads" : "ren_abort/loads", 64'(n_load - bl), 64'd0);
    stim.delete();
  endtask

  initial begin
    int e, bq;
    logic [63:0] gv;
    bus.serial_rx_tick_i   = 1'b0;
    bus.serial_rxd_i       = 1'b1;
    bus.serial_scon4_ren_i = 1'b0;
    bus.serial_scon7_sm0_i = 1'b0;
    bus.serial_scon6_sm1_i = 1'b0;
    bus.serial_scon5_sm2_i = 1'b0;
    bus.serial_scon0_ri_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset/outputs", 64'(out_vec()), 64'(7'b0010000));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 1, 0xA5 + stop bit; also checked against the literal bit order
    add_idle(4);
    void'(add_frame(8'hA5, 1'b1));
    add_idle(20);
    bq = shift_q.size();
    run_stream("m1_a5", 1'b0, 1'b1, 1'b0, 1'b0);
    gv = '0;
    for (int i = 0; i < shift_q.size() - bq && i < 64; i++) gv[i] = shift_q[bq+i];
    check_value("m1_a5/literal", gv, 64'h1A5);

    // False start followed by a valid 0x3C frame
    add_idle(4);
    for (int i = 0; i < 4; i++) stim.push_back(1'b0);
    add_idle(16);
    void'(add_frame(8'h3C, 1'b1));
    add_idle(20);
    run_stream("false_start", 1'b0, 1'b1, 1'b0, 1'b0);

    add_idle(4); void'(add_frame(8'h55, 1'b0)); add_idle(20);
    run_stream("m2_sm2_b9_0", 1'b1, 1'b0, 1'b1, 1'b0);
    add_idle(4); void'(add_frame(8'h55, 1'b1)); add_idle(20);
    run_stream("m2_sm2_b9_1", 1'b1, 1'b0, 1'b1, 1'b0);
    add_idle(4); void'(add_frame(8'hFF, 1'b1)); add_idle(20);
    run_stream("m3_ri_set", 1'b1, 1'b1, 1'b0, 1'b1);
    add_idle(4); void'(add_frame(8'h96, 1'b1)); add_idle(20);
    run_stream("mode0", 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch: centre sample of data bit 2 inverted
    add_idle(4);
    e = add_frame(8'hA5, 1'b1);
    stim[e + 16 + 32 + 9] = 1'b0;
    add_idle(20);
    bq = shift_q.size();
    run_stream("glitch", 1'b0, 1'b1, 1'b0, 1'b0);
    check_value("glitch/bit2", 64'(shift_q[bq+2]), 64'd1);

    run_abort(1'b0);
    run_abort(1'b1);

    for (int r = 0; r < 14; r++) begin
      logic [1:0] mode;
      mode = 2'($urandom_range(0, 3));
      add_idle(2 + $urandom_range(0, 8));
      e = add_frame(8'($urandom), 1'($urandom));
      for (int j = 0; j < 10; j++)
        if ($urandom_range(0, 1) == 1) stim[e + 16*j + 8 + $urandom_range(0, 2)] ^= 1'b1;
      add_idle(20);
      run_stream($sformatf("rand%0d", r), mode[1], mode[0], 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
